fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the PC, issues word requests to the instruction memory and buffers returned instructions in a small queue. It presents one instruction per cycle with its PC+4, honours the IF/ID load-enable stall, and squashes wrong-path fetches on a taken branch redirect.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue.sv | 53 +++++
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    F_IDLE,
    F_WAIT,
    F_DRAIN
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] PC_INC    = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] next_pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {instr, next_pc} pairs.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  fetch_entry_t               data_i,
  output logic [$clog2(QDEPTH):0]    count_o,
  output fetch_entry_t               head_o
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  fetch_entry_t  mem_q [QDEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + PTR_ONE;
      end
      if (pop_i) begin
        rd_q <= rd_q + PTR_ONE;
      end
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding memory request FSM,
// and a small instruction queue feeding the IF/ID register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        ifid_ready,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_next_pc
);

  localparam int AW = $clog2(QDEPTH);
  localparam int OW = AW + 2;
  localparam logic [OW-1:0] DEPTH = OW'(QDEPTH);

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_q, req_d;
  logic [AW:0]   q_count;
  fetch_entry_t  head, entry;
  logic          push, pop, flush;
  logic          deq, issue;
  logic [OW-1:0] occ;

  assign ifid_valid = (q_count != '0);
  assign deq        = ifid_valid && ifid_ready;
  // occupancy after this cycle's response lands and head leaves
  assign occ        = OW'(q_count) + OW'(1) - OW'(deq);

  always_comb begin
    issue = 1'b0;
    if (reset && !branch) begin
      unique case (state_q)
        F_IDLE:  issue = (OW'(q_count) < DEPTH);
        F_WAIT:  issue = imem_rvalid && (occ < DEPTH);
        default: issue = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    push    = 1'b0;
    pop     = deq && !branch;
    flush   = branch;
    if (issue) begin
      pc_d  = pc_q + PC_INC;
      req_d = pc_q;
    end
    if (branch) begin
      pc_d = {branch_target[31:2], 2'b00};
    end
    unique case (state_q)
      F_IDLE: begin
        if (issue) state_d = F_WAIT;
      end
      F_WAIT: begin
        if (imem_rvalid) begin
          push    = !branch;
          state_d = issue ? F_WAIT : F_IDLE;
        end else if (branch) begin
          state_d = F_DRAIN;
        end
      end
      F_DRAIN: begin
        if (imem_rvalid) state_d = F_IDLE;
      end
      default: state_d = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= F_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
    end
  end

  assign entry = '{instr: imem_rdata, next_pc: req_q + PC_INC};

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_q (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (entry),
    .count_o (q_count),
    .head_o  (head)
  );

  assign imem_req     = issue;
  assign imem_addr    = pc_q;
  assign ifid_instr   = ifid_valid ? head.instr   : NOP_INSTR;
  assign ifid_next_pc = ifid_valid ? head.next_pc : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable memory model, in-order
// scoreboard of expected {instr, next_pc}, plus directed corner cases.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        branch;
  logic [31:0] branch_target;
  logic        ifid_ready;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_next_pc;

  int n_cmp = 0;
  int n_err = 0;
  int n_deliv = 0;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .QDEPTH   (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .branch        (branch),
    .branch_target (branch_target),
    .ifid_ready    (ifid_ready),
    .ifid_valid    (ifid_valid),
    .ifid_instr    (ifid_instr),
    .ifid_next_pc  (ifid_next_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    if (a == 32'h0) return 32'hE3A0_1005;
    if (a == 32'h4) return 32'hE3A0_2003;
    return 32'h0001_0013 + a;
  endfunction

  // memory model: response lat cycles after the request edge
  int          lat;
  logic        pend;
  int          cnt;
  logic [31:0] paddr;

  assign imem_rvalid = pend && (cnt == 0);
  assign imem_rdata  = imem_rvalid ? instr_of(paddr) : 32'h0;

  always @(posedge clk) begin
    if (!reset) begin
      pend <= 1'b0;
      cnt  <= 0;
    end else begin
      if (imem_rvalid) pend <= 1'b0;
      else if (pend) cnt <= cnt - 1;
      if (imem_req) begin
        pend  <= 1'b1;
        cnt   <= lat - 1;
        paddr <= imem_addr;
      end
    end
  end

  // scoreboard: expectation built from the bench's own program counter
  logic [63:0] sb[$];
  logic [31:0] ref_pc;

  always @(negedge clk) begin
    logic [63:0] e;
    if (!reset) begin
      sb.delete();
      ref_pc = RESET_PC;
    end else begin
      if (imem_req) begin
        chk("req_addr", imem_addr, ref_pc);
        chk("one_outstanding", {31'b0, pend && !imem_rvalid}, 32'h0);
        sb.push_back({instr_of(ref_pc), ref_pc + 32'd4});
        ref_pc = ref_pc + 32'd4;
      end
      if (dut.push) begin
        chk("no_overflow", {31'b0, dut.q_count < 2}, 32'h1);
      end
      if (ifid_valid && ifid_ready && !branch) begin
        n_deliv++;
        if (sb.size() == 0) begin
          chk("sb_underrun", 32'h1, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("deliv_instr", ifid_instr, e[63:32]);
          chk("deliv_next_pc", ifid_next_pc, e[31:0]);
        end
      end
      if (branch) begin
        sb.delete();
        ref_pc = {branch_target[31:2], 2'b00};
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20 && !imem_req; i++) step();
    chk(tag, {31'b0, imem_req}, 32'h1);
  endtask

  initial begin
    logic [31:0] held;
    reset         = 1'b0;
    branch        = 1'b0;
    branch_target = 32'h0;
    ifid_ready    = 1'b1;
    lat           = 1;
    step();
    step();
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_npc", ifid_next_pc, 32'h0);

    // release: requests 0, 4, ... ; first instr 2 cycles after request
    reset = 1'b1;
    #1;
    chk("c0_req", {31'b0, imem_req}, 32'h1);
    chk("c0_addr", imem_addr, 32'h0);
    step();
    chk("c1_addr", imem_addr, 32'h4);
    chk("c1_valid", {31'b0, ifid_valid}, 32'h0);
    step();
    chk("c2_valid", {31'b0, ifid_valid}, 32'h1);
    chk("c2_instr", ifid_instr, 32'hE3A0_1005);
    chk("c2_npc", ifid_next_pc, 32'h4);
    chk("c2_addr", imem_addr, 32'h8);
    step();
    chk("c3_instr", ifid_instr, 32'hE3A0_2003);
    chk("c3_npc", ifid_next_pc, 32'h8);

    // stall for 5 cycles
    ifid_ready = 1'b0;
    #1;
    held = ifid_instr;
    repeat (5) step();
    chk("stall_count", 32'(dut.q_count), 32'h2);
    chk("stall_req", {31'b0, imem_req}, 32'h0);
    chk("stall_head", ifid_instr, held);
    ifid_ready = 1'b1;
    repeat (10) step();

    // branch while waiting on a 3-cycle memory
    lat = 3;
    repeat (4) step();
    for (int i = 0; i < 20; i++) begin
      if (dut.state_q == F_WAIT && !imem_rvalid) break;
      step();
    end
    chk("br_in_wait", 32'(dut.state_q), 32'(F_WAIT));
    branch        = 1'b1;
    branch_target = 32'h40;
    step();
    branch = 1'b0;
    #1;
    chk("drain_noreq", {31'b0, imem_req}, 32'h0);
    chk("drain_valid", {31'b0, ifid_valid}, 32'h0);
    wait_req("br_req_timeout");
    chk("br_addr", imem_addr, 32'h40);
    for (int i = 0; i < 20 && !ifid_valid; i++) step();
    chk("br_first_valid", {31'b0, ifid_valid}, 32'h1);
    chk("br_first_npc", ifid_next_pc, 32'h44);
    chk("br_first_instr", ifid_instr, instr_of(32'h40));

    // branch coinciding with a response and a dequeue
    lat = 1;
    repeat (6) step();
    for (int i = 0; i < 20 && !imem_rvalid; i++) step();
    chk("br_rv_present", {31'b0, imem_rvalid}, 32'h1);
    lat           = 4;
    branch        = 1'b1;
    branch_target = 32'h83;
    step();
    branch = 1'b0;
    #1;
    chk("brrv_valid", {31'b0, ifid_valid}, 32'h0);
    chk("brrv_req", {31'b0, imem_req}, 32'h1);
    chk("brrv_addr", imem_addr, 32'h80);

    // 4-cycle latency into an empty queue presents NOP
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lat4_valid", {31'b0, ifid_valid}, 32'h0);
      chk("lat4_instr", ifid_instr, 32'h0);
      chk("lat4_npc", ifid_next_pc, 32'h0);
    end
    step();
    chk("lat4_arrive", {31'b0, ifid_valid}, 32'h1);
    chk("lat4_npc_arr", ifid_next_pc, 32'h84);

    // reset mid-flight with queued entries
    lat        = 3;
    ifid_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (dut.state_q == F_WAIT && dut.q_count != 0) break;
      step();
    end
    chk("mid_wait", 32'(dut.state_q), 32'(F_WAIT));
    reset = 1'b0;
    step();
    chk("mrst_req", {31'b0, imem_req}, 32'h0);
    chk("mrst_addr", imem_addr, RESET_PC);
    chk("mrst_valid", {31'b0, ifid_valid}, 32'h0);
    chk("mrst_instr", ifid_instr, 32'h0);
    chk("mrst_npc", ifid_next_pc, 32'h0);
    chk("mrst_state", 32'(dut.state_q), 32'(F_IDLE));
    reset      = 1'b1;
    ifid_ready = 1'b1;
    lat        = 1;
    #1;
    chk("mrst_first_req", {31'b0, imem_req}, 32'h1);
    chk("mrst_first_addr", imem_addr, RESET_PC);
    repeat (8) step();

    // random stalls, latencies and redirects
    for (int i = 0; i < 300; i++) begin
      ifid_ready    = ($urandom_range(0, 3) != 0);
      lat           = $urandom_range(1, 3);
      branch        = ($urandom_range(0, 15) == 0);
      branch_target = $urandom & 32'h0000_0FFF;
      step();
    end
    branch     = 1'b0;
    ifid_ready = 1'b1;
    repeat (10) step();
    chk("deliv_enough", {31'b0, n_deliv > 100}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
